// File: rtl/reg_file_streamer.sv
// rtl/reg_file_streamer.sv - block load/dump sequencer for a 2^ADDR_WIDTH x DATA_WIDTH register file
module reg_file_streamer #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic                  Start,
    input  logic                  Mode,
    input  logic [ADDR_WIDTH-1:0] BaseAddress,
    input  logic [ADDR_WIDTH:0]   Count,
    output logic                  Busy,
    output logic                  Done,
    output logic [ADDR_WIDTH-1:0] AddressA,
    output logic [ADDR_WIDTH-1:0] AddressB,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  WriteEnable,
    input  logic [DATA_WIDTH-1:0] ReadDataA,
    input  logic [DATA_WIDTH-1:0] ReadDataB,
    output logic [DATA_WIDTH-1:0] OutData,
    output logic                  OutValid,
    input  logic                  OutReady,
    input  logic [DATA_WIDTH-1:0] InData,
    input  logic                  InValid,
    output logic                  InReady
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        EMIT_A = 3'd2,
        EMIT_B = 3'd3,
        LOAD   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH:0]   LAST_WORD = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] STEP_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] STEP_TWO  = ADDR_WIDTH'(2);

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   ptr, ptr_next;
    logic [ADDR_WIDTH:0]     remaining, remaining_next;
    logic [DATA_WIDTH-1:0]   hold_a, hold_b;

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            hold_a    <= '0;
            hold_b    <= '0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            remaining <= remaining_next;
            if (state == READ) begin
                hold_a <= ReadDataA;
                hold_b <= ReadDataB;
            end
        end
    end

    // Stream outputs come only from flops: the state register and the hold registers.
    assign OutValid = (state == EMIT_A) || (state == EMIT_B);
    assign OutData  = (state == EMIT_B) ? hold_b : hold_a;

    always_comb begin
        state_next     = state;
        ptr_next       = ptr;
        remaining_next = remaining;
        Busy           = (state != IDLE);
        Done           = 1'b0;
        AddressA       = '0;
        AddressB       = '0;
        WriteData      = '0;
        WriteEnable    = 1'b0;
        InReady        = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (Count == '0) begin
                        state_next = DONE;
                    end else begin
                        ptr_next       = BaseAddress;
                        remaining_next = Count;
                        state_next     = Mode ? LOAD : READ;
                    end
                end
            end
            READ: begin
                AddressA   = ptr;
                AddressB   = ptr + STEP_ONE;
                state_next = EMIT_A;
            end
            EMIT_A: begin
                if (OutReady) begin
                    remaining_next = remaining - LAST_WORD;
                    state_next     = (remaining == LAST_WORD) ? DONE : EMIT_B;
                end
            end
            EMIT_B: begin
                if (OutReady) begin
                    remaining_next = remaining - LAST_WORD;
                    ptr_next       = ptr + STEP_TWO;
                    state_next     = (remaining == LAST_WORD) ? DONE : READ;
                end
            end
            LOAD: begin
                InReady   = 1'b1;
                AddressA  = ptr;
                WriteData = InData;
                // Gated by reset so the word presented on a reset edge is never committed.
                WriteEnable = InValid & nReset;
                if (InValid) begin
                    ptr_next       = ptr + STEP_ONE;
                    remaining_next = remaining - LAST_WORD;
                    if (remaining == LAST_WORD) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_file_streamer.sv
// tb/tb_reg_file_streamer.sv - randomized directed bench for reg_file_streamer with a register file model
module tb_reg_file_streamer;

    logic        Clock = 1'b0;
    logic        nReset;
    logic        Start;
    logic        Mode;
    logic [5:0]  BaseAddress;
    logic [6:0]  Count;
    logic        Busy;
    logic        Done;
    logic [5:0]  AddressA;
    logic [5:0]  AddressB;
    logic [15:0] WriteData;
    logic        WriteEnable;
    logic [15:0] ReadDataA;
    logic [15:0] ReadDataB;
    logic [15:0] OutData;
    logic        OutValid;
    logic        OutReady;
    logic [15:0] InData;
    logic        InValid;
    logic        InReady;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [64] = '{default: 16'h0};
    logic [15:0] ref_mem [64] = '{default: 16'h0};

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (WriteEnable) mem[AddressA] <= WriteData;
    end
    assign ReadDataA = mem[AddressA];
    assign ReadDataB = mem[AddressB];

    reg_file_streamer #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) dut (
        .Clock(Clock), .nReset(nReset), .Start(Start), .Mode(Mode),
        .BaseAddress(BaseAddress), .Count(Count), .Busy(Busy), .Done(Done),
        .AddressA(AddressA), .AddressB(AddressB), .WriteData(WriteData),
        .WriteEnable(WriteEnable), .ReadDataA(ReadDataA), .ReadDataB(ReadDataB),
        .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
        .InData(InData), .InValid(InValid), .InReady(InReady)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic do_start(input logic mode, input int base, input int cnt);
        Start = 1'b1;
        Mode = mode;
        BaseAddress = 6'(base);
        Count = 7'(cnt);
        tick();
        Start = 1'b0;
    endtask

    task automatic check_idle_after_done();
        tick();
        #1;
        check("done_one_cycle", Done, 1'b0);
        check("busy_falls", Busy, 1'b0);
    endtask

    task automatic run_load(input int base, input int cnt, input int stall_pct, input int stall_at);
        logic [15:0] d[$];
        int idx = 0;
        int cyc = 0;
        logic vld;
        for (int i = 0; i < cnt; i++) d.push_back(16'($urandom));
        do_start(1'b1, base, cnt);
        while (idx < cnt && cyc < 400) begin
            if (cyc == stall_at || cyc == stall_at + 1) vld = 1'b0;
            else vld = ($urandom_range(99) >= stall_pct);
            InValid = vld;
            InData = d[idx];
            #1;
            check("load_inready", InReady, 1'b1);
            check("load_we", WriteEnable, vld);
            check("load_addr", AddressA, (base + idx) % 64);
            if (vld) check("load_wdata", WriteData, d[idx]);
            tick();
            if (vld) begin
                ref_mem[(base + idx) % 64] = d[idx];
                idx++;
            end
            cyc++;
        end
        InValid = 1'b0;
        #1;
        check("load_words", idx, cnt);
        check("load_done", Done, 1'b1);
        check("load_no_we_in_done", WriteEnable, 1'b0);
        check_idle_after_done();
    endtask

    task automatic run_dump(input int base, input int cnt, input int ready_mode, input int restart_at);
        int n = 0;
        int cyc = 0;
        logic rdy, hs;
        do_start(1'b0, base, cnt);
        while (n < cnt && cyc < 600) begin
            case (ready_mode)
                0: rdy = 1'b1;
                1: rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom);
            endcase
            OutReady = rdy;
            Start = (cyc == restart_at);
            Mode = 1'($urandom);
            BaseAddress = 6'($urandom);
            Count = 7'($urandom);
            #1;
            if (cyc == 0) check("dump_read_no_valid", OutValid, 1'b0);
            if (cyc == 1) check("dump_first_valid", OutValid, 1'b1);
            if (OutValid) check("dump_data", OutData, ref_mem[(base + n) % 64]);
            check("dump_no_we", WriteEnable, 1'b0);
            hs = OutValid && rdy;
            tick();
            if (hs) n++;
            cyc++;
        end
        Start = 1'b0;
        #1;
        check("dump_words", n, cnt);
        check("dump_done", Done, 1'b1);
        check("dump_no_extra_valid", OutValid, 1'b0);
        if (ready_mode == 0) check("dump_cycles", cyc, cnt + (cnt + 1) / 2);
        check_idle_after_done();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, Busy, 1'b0);
        check({tag, "_done"}, Done, 1'b0);
        check({tag, "_outvalid"}, OutValid, 1'b0);
        check({tag, "_inready"}, InReady, 1'b0);
        check({tag, "_we"}, WriteEnable, 1'b0);
        check({tag, "_addra"}, AddressA, 6'h0);
        check({tag, "_addrb"}, AddressB, 6'h0);
        check({tag, "_wdata"}, WriteData, 16'h0);
        check({tag, "_outdata"}, OutData, 16'h0);
    endtask

    initial begin
        logic [15:0] w;
        nReset = 1'b0;
        Start = 1'b0;
        Mode = 1'b0;
        BaseAddress = '0;
        Count = '0;
        OutReady = 1'b0;
        InData = '0;
        InValid = 1'b0;
        tick();
        tick();
        #1;
        check_all_zero("reset");
        nReset = 1'b1;
        tick();

        run_load(0, 6, 0, -1);
        run_dump(0, 6, 0, -1);
        run_load(62, 4, 0, -1);
        run_dump(62, 4, 0, -1);
        run_dump(62, 3, 1, -1);
        run_load(20, 8, 0, 3);
        run_dump(20, 8, 0, 2);

        // Zero-length transfer with load stream offered
        InValid = 1'b1;
        do_start(1'b1, 5, 0);
        #1;
        check("zero_done", Done, 1'b1);
        check("zero_busy", Busy, 1'b1);
        check("zero_we", WriteEnable, 1'b0);
        check("zero_outvalid", OutValid, 1'b0);
        check("zero_inready", InReady, 1'b0);
        InValid = 1'b0;
        check_idle_after_done();

        // Reset in the middle of a load
        do_start(1'b1, 10, 5);
        for (int i = 0; i < 2; i++) begin
            w = 16'($urandom);
            InValid = 1'b1;
            InData = w;
            tick();
            ref_mem[10 + i] = w;
        end
        InValid = 1'b1;
        InData = ~ref_mem[12];
        nReset = 1'b0;
        #1;
        check("rst_we_gated", WriteEnable, 1'b0);
        tick();
        #1;
        check_all_zero("midrst");
        nReset = 1'b1;
        InValid = 1'b0;
        tick();
        #1;
        check("midrst_no_done", Done, 1'b0);
        check("midrst_idle", Busy, 1'b0);
        run_dump(10, 5, 0, -1);

        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(1) == 1) run_load($urandom_range(63), $urandom_range(70, 1), 30, -1);
            else run_dump($urandom_range(63), $urandom_range(70, 1), 2, -1);
        end
        run_dump(0, 64, 2, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
